// File: rtl/d_cache_pkg.sv
// Shared types and helpers for the N-way write-back data cache.
package d_cache_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_WB     = 2'd2,
      S_REFILL = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] m;
      case (size)
         SIZE_BYTE: m = 4'b0001 << addr_lo;
         SIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:   m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] expand_mask(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

endpackage

// File: rtl/d_cache_nway_plru_plru_tree.sv
// Tree pseudo-LRU for one set: victim walk and update-on-use, purely combinational.
module plru_tree #(
   parameter int WAY_LOG2 = 2
) (
   input  logic [(1<<WAY_LOG2)-2:0] tree_i,
   input  logic [WAY_LOG2-1:0]      use_way,
   output logic [WAY_LOG2-1:0]      victim_way,
   output logic [(1<<WAY_LOG2)-2:0] tree_next
);
   localparam int WAYS = 1 << WAY_LOG2;
   localparam int TW   = WAYS - 1;

   // Node n (heap order, root = 1) lives in bit n-1.
   always_comb begin
      int node;
      logic [TW-1:0] sh;
      node = 1;
      for (int l = 0; l < WAY_LOG2; l++) begin
         sh   = tree_i >> (node - 1);
         node = 2 * node + int'(sh[0]);
      end
      victim_way = WAY_LOG2'(node - WAYS);
   end

   always_comb begin
      int node;
      logic [WAY_LOG2-1:0] sh;
      logic dir;
      tree_next = tree_i;
      node      = 1;
      for (int l = 0; l < WAY_LOG2; l++) begin
         sh        = use_way >> (WAY_LOG2 - 1 - l);
         dir       = sh[0];
         tree_next = (tree_next & ~(TW'(1) << (node - 1))) | (TW'(!dir) << (node - 1));
         node      = 2 * node + int'(dir);
      end
   end

endmodule

// File: rtl/d_cache_nway_plru.sv
// Set-associative write-back/write-allocate data cache, tree-PLRU replacement,
// word-by-word refill and write-back over an sram-like single-beat port.
//
// state    | meaning
// S_IDLE   | waiting for a core request
// S_LOOKUP | tag compare; hit completes, miss picks a victim
// S_WB     | writing the dirty victim line back, one word per beat
// S_REFILL | reading the requested line into the victim way
module d_cache_nway_plru
   import d_cache_pkg::*;
#(
   parameter int INDEX_WIDTH  = 7,
   parameter int OFFSET_WIDTH = 4,
   parameter int WAY_LOG2     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_data_req,
   input  logic        cpu_data_wr,
   input  logic [1:0]  cpu_data_size,
   input  logic [31:0] cpu_data_addr,
   input  logic [31:0] cpu_data_wdata,
   output logic [31:0] cpu_data_rdata,
   output logic        cpu_data_addr_ok,
   output logic        cpu_data_data_ok,
   output logic        cache_data_req,
   output logic        cache_data_wr,
   output logic [1:0]  cache_data_size,
   output logic [31:0] cache_data_addr,
   output logic [31:0] cache_data_wdata,
   input  logic [31:0] cache_data_rdata,
   input  logic        cache_data_addr_ok,
   input  logic        cache_data_data_ok
);
   localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int SETS      = 1 << INDEX_WIDTH;
   localparam int WAYS      = 1 << WAY_LOG2;
   localparam int BEAT_W    = OFFSET_WIDTH - 2;
   localparam int LW        = 1 << BEAT_W;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LW - 1);

   state_t              state_q, state_d;
   logic [31:0]         req_addr_q, req_addr_d;
   logic [31:0]         req_wdata_q, req_wdata_d;
   logic                req_wr_q, req_wr_d;
   logic [1:0]          req_size_q, req_size_d;
   logic [WAY_LOG2-1:0] victim_way_q, victim_way_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic                addr_acc_q, addr_acc_d;

   logic [31:0]          data_q  [WAYS][SETS][LW];
   logic [TAG_WIDTH-1:0] tag_q   [WAYS][SETS];
   logic [WAYS-1:0]      valid_q [SETS];
   logic [WAYS-1:0]      dirty_q [SETS];
   logic [WAYS-2:0]      plru_q  [SETS];

   logic [INDEX_WIDTH-1:0] idx;
   logic [TAG_WIDTH-1:0]   req_tag, victim_tag;
   logic [BEAT_W-1:0]      word_sel;
   logic                   hit, inv_found, busy, last_beat;
   logic [WAY_LOG2-1:0]    hit_way, inv_way, plru_victim, miss_way;
   logic [WAYS-2:0]        plru_next;
   logic [31:0]            hit_word, bitmask, merged_word;

   logic                data_we, fill_done, plru_we, dirty_set, dirty_clr;
   logic [WAY_LOG2-1:0] data_way;
   logic [BEAT_W-1:0]   data_word;
   logic [31:0]         data_wval;

   assign idx        = req_addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
   assign req_tag    = req_addr_q[31 -: TAG_WIDTH];
   assign word_sel   = req_addr_q[OFFSET_WIDTH-1:2];
   assign victim_tag = tag_q[victim_way_q][idx];
   assign busy       = (state_q == S_WB) || (state_q == S_REFILL);
   assign last_beat  = (beat_cnt_q == LAST_BEAT);

   // Descending scan so the lowest-numbered invalid way wins.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && (tag_q[w][idx] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_LOG2'(w);
         end
         if (!valid_q[idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_LOG2'(w);
         end
      end
   end

   plru_tree #(.WAY_LOG2(WAY_LOG2)) u_plru (
      .tree_i     (plru_q[idx]),
      .use_way    (hit_way),
      .victim_way (plru_victim),
      .tree_next  (plru_next)
   );

   assign miss_way    = inv_found ? inv_way : plru_victim;
   assign hit_word    = data_q[hit_way][idx][word_sel];
   assign bitmask     = expand_mask(byte_mask(req_size_q, req_addr_q[1:0]));
   assign merged_word = (hit_word & ~bitmask) | (req_wdata_q & bitmask);

   assign cpu_data_addr_ok = cpu_data_req && (state_q == S_IDLE);
   assign cache_data_req   = busy && !addr_acc_q;
   assign cache_data_wr    = (state_q == S_WB);
   assign cache_data_size  = SIZE_WORD;
   assign cache_data_addr  = busy ? {(state_q == S_WB) ? victim_tag : req_tag, idx, beat_cnt_q, 2'b00}
                                  : 32'd0;
   assign cache_data_wdata = (state_q == S_WB) ? data_q[victim_way_q][idx][beat_cnt_q] : 32'd0;

   always_comb begin
      state_d          = state_q;
      req_addr_d       = req_addr_q;
      req_wdata_d      = req_wdata_q;
      req_wr_d         = req_wr_q;
      req_size_d       = req_size_q;
      victim_way_d     = victim_way_q;
      beat_cnt_d       = beat_cnt_q;
      addr_acc_d       = addr_acc_q;
      data_we          = 1'b0;
      data_way         = hit_way;
      data_word        = word_sel;
      data_wval        = merged_word;
      fill_done        = 1'b0;
      plru_we          = 1'b0;
      dirty_set        = 1'b0;
      dirty_clr        = 1'b0;
      cpu_data_data_ok = 1'b0;
      cpu_data_rdata   = 32'd0;
      case (state_q)
         S_IDLE: begin
            if (cpu_data_req) begin
               req_addr_d  = cpu_data_addr;
               req_wdata_d = cpu_data_wdata;
               req_wr_d    = cpu_data_wr;
               req_size_d  = cpu_data_size;
               state_d     = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               cpu_data_data_ok = 1'b1;
               plru_we          = 1'b1;
               if (req_wr_q) begin
                  data_we   = 1'b1;
                  dirty_set = 1'b1;
               end else begin
                  cpu_data_rdata = hit_word;
               end
               state_d = S_IDLE;
            end else begin
               victim_way_d = miss_way;
               beat_cnt_d   = '0;
               addr_acc_d   = 1'b0;
               state_d      = (valid_q[idx][miss_way] && dirty_q[idx][miss_way]) ? S_WB : S_REFILL;
            end
         end
         S_WB, S_REFILL: begin
            // data_ok closes the beat even when it coincides with addr_ok.
            if (cache_data_data_ok) begin
               addr_acc_d = 1'b0;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (state_q == S_REFILL) begin
                  data_we   = 1'b1;
                  data_way  = victim_way_q;
                  data_word = beat_cnt_q;
                  data_wval = cache_data_rdata;
               end
               if (last_beat) begin
                  if (state_q == S_WB) begin
                     dirty_clr = 1'b1;
                     state_d   = S_REFILL;
                  end else begin
                     fill_done = 1'b1;
                     state_d   = S_LOOKUP;
                  end
               end
            end else if (cache_data_req && cache_data_addr_ok) begin
               addr_acc_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         req_wr_q     <= 1'b0;
         req_size_q   <= '0;
         victim_way_q <= '0;
         beat_cnt_q   <= '0;
         addr_acc_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_wr_q     <= req_wr_d;
         req_size_q   <= req_size_d;
         victim_way_q <= victim_way_d;
         beat_cnt_q   <= beat_cnt_d;
         addr_acc_q   <= addr_acc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         if (plru_we) plru_q[idx] <= plru_next;
         if (fill_done) begin
            valid_q[idx][victim_way_q] <= 1'b1;
            dirty_q[idx][victim_way_q] <= 1'b0;
         end
         if (dirty_set) dirty_q[idx][hit_way]      <= 1'b1;
         if (dirty_clr) dirty_q[idx][victim_way_q] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && data_we) data_q[data_way][idx][data_word] <= data_wval;
      if (!rst && fill_done) tag_q[victim_way_q][idx] <= req_tag;
   end

endmodule

// File: tb/tb_d_cache_nway_plru.sv
// Randomised scoreboard bench for d_cache_nway_plru with a line-level cache
// model and a delaying single-beat memory bridge.
module tb_d_cache_nway_plru;
   localparam int IW   = 7;
   localparam int OW   = 4;
   localparam int WL   = 2;
   localparam int WAYS = 1 << WL;
   localparam int LW   = 1 << (OW - 2);
   localparam int SETS = 1 << IW;
   localparam int TW   = 32 - IW - OW;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_data_req, cpu_data_wr;
   logic [1:0]  cpu_data_size;
   logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
   logic        cpu_data_addr_ok, cpu_data_data_ok;
   logic        cache_data_req, cache_data_wr;
   logic [1:0]  cache_data_size;
   logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
   logic        cache_data_addr_ok, cache_data_data_ok;

   always #5 clk = ~clk;

   d_cache_nway_plru #(.INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .WAY_LOG2(WL)) dut (
      .clk(clk), .rst(rst),
      .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr), .cpu_data_size(cpu_data_size),
      .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
      .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
      .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr), .cache_data_size(cache_data_size),
      .cache_data_addr(cache_data_addr), .cache_data_wdata(cache_data_wdata),
      .cache_data_rdata(cache_data_rdata), .cache_data_addr_ok(cache_data_addr_ok),
      .cache_data_data_ok(cache_data_data_ok)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { bit is_load; logic [31:0] rdata; bit hit; int acc_cyc; } exp_t;
   typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; } beat_t;
   exp_t  exp_q[$];
   beat_t beat_q[$];

   logic [31:0] mem [logic [31:0]];

   bit          m_valid [WAYS][SETS];
   bit          m_dirty [WAYS][SETS];
   logic [TW-1:0] m_tag [WAYS][SETS];
   logic [31:0] m_data  [WAYS][SETS][LW];
   bit          m_plru  [SETS][WAYS];

   int max_dly      = 0;
   int beats_done   = 0;
   int last_dok_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] line_addr(input int tag, input int idx, input int k);
      return 32'((tag << (IW + OW)) | (idx << OW) | (k << 2));
   endfunction

   function automatic void model_reset();
      for (int w = 0; w < WAYS; w++)
         for (int s = 0; s < SETS; s++) begin
            m_valid[w][s] = 0;
            m_dirty[w][s] = 0;
         end
      for (int s = 0; s < SETS; s++)
         for (int n = 0; n < WAYS; n++) m_plru[s][n] = 0;
   endfunction

   // Line-level reference: hit/miss, victim choice, expected beats, PLRU, merge.
   function automatic void model_access(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] wdata, output exp_t e);
      int idx, tag, word, way, node, first, nb;
      beat_t b;
      idx  = int'(addr[OW +: IW]);
      tag  = int'(addr[31 -: TW]);
      word = int'(addr[OW-1:2]);
      way  = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[w][idx] && int'(m_tag[w][idx]) == tag) way = w;
      e.hit = (way >= 0);
      e.is_load = !wr;
      e.rdata = 32'd0;
      if (way < 0) begin
         for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w][idx]) way = w;
         if (way < 0) begin
            node = 1;
            while (node < WAYS) node = 2 * node + int'(m_plru[idx][node]);
            way = node - WAYS;
         end
         if (m_valid[way][idx] && m_dirty[way][idx])
            for (int k = 0; k < LW; k++) begin
               b.wr = 1; b.addr = line_addr(int'(m_tag[way][idx]), idx, k); b.wdata = m_data[way][idx][k];
               beat_q.push_back(b);
            end
         for (int k = 0; k < LW; k++) begin
            b.wr = 0; b.addr = line_addr(tag, idx, k); b.wdata = 32'd0;
            beat_q.push_back(b);
            m_data[way][idx][k] = mem_rd(b.addr);
         end
         m_tag[way][idx]   = TW'(tag);
         m_valid[way][idx] = 1;
         m_dirty[way][idx] = 0;
      end
      node = 1;
      for (int l = 0; l < WL; l++) begin
         int dir;
         dir = (way >> (WL - 1 - l)) & 1;
         m_plru[idx][node] = (dir == 0);
         node = 2 * node + dir;
      end
      if (wr) begin
         nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
         first = (size == 2'd0) ? int'(addr[1:0]) : (size == 2'd1) ? 2 * int'(addr[1]) : 0;
         for (int bl = 0; bl < 4; bl++)
            if (bl >= first && bl < first + nb) m_data[way][idx][word][8*bl +: 8] = wdata[8*bl +: 8];
         m_dirty[way][idx] = 1;
      end else begin
         e.rdata = m_data[way][idx][word];
      end
   endfunction

   // Memory bridge: random addr_ok / data_ok delays, checks every accepted beat.
   initial begin
      bit pend, armed, b_wr;
      int a_cnt, d_cnt;
      logic [31:0] b_addr;
      beat_t eb;
      cache_data_addr_ok = 0; cache_data_data_ok = 0; cache_data_rdata = 0;
      pend = 0; armed = 0; a_cnt = 0; d_cnt = 0; b_wr = 0; b_addr = 0;
      forever begin
         @(negedge clk);
         cache_data_addr_ok = 0;
         cache_data_data_ok = 0;
         if (rst) begin
            pend = 0; armed = 0;
         end else if (pend) begin
            check("req_reasserted_while_pending", cache_data_req, 1'b0);
            if (d_cnt == 0) begin
               cache_data_data_ok = 1;
               cache_data_rdata = b_wr ? 32'd0 : mem_rd(b_addr);
               beats_done++; last_dok_cyc = cyc; pend = 0;
            end else d_cnt--;
         end else if (cache_data_req) begin
            if (!armed) begin a_cnt = $urandom_range(max_dly, 0); armed = 1; end
            if (a_cnt == 0) begin
               armed = 0;
               cache_data_addr_ok = 1;
               b_wr = cache_data_wr; b_addr = cache_data_addr;
               check("beat_size", cache_data_size, 2'b10);
               if (beat_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_beat: got addr 0x%08h wr %0d expected no beat", b_addr, b_wr);
               end else begin
                  eb = beat_q.pop_front();
                  check("beat_addr", b_addr, eb.addr);
                  check("beat_wr", b_wr, eb.wr);
                  if (eb.wr) begin
                     check("beat_wdata", cache_data_wdata, eb.wdata);
                     mem[eb.addr] = eb.wdata;
                  end
               end
               d_cnt = $urandom_range(max_dly, 0);
               if (d_cnt == 0) begin
                  cache_data_data_ok = 1;
                  cache_data_rdata = b_wr ? 32'd0 : mem_rd(b_addr);
                  beats_done++; last_dok_cyc = cyc;
               end else begin
                  pend = 1; d_cnt--;
               end
            end else a_cnt--;
         end
      end
   end

   // Core-side monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && cpu_data_data_ok) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_data_ok: got data_ok 1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               if (e.is_load) check("load_rdata", cpu_data_rdata, e.rdata);
               check("data_ok_cycle", cyc, e.hit ? e.acc_cyc + 1 : last_dok_cyc + 1);
            end
         end
      end
   end

   task automatic issue(input bit wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      int t;
      @(posedge clk); #1;
      cpu_data_req = 1; cpu_data_wr = wr; cpu_data_size = size;
      cpu_data_addr = addr; cpu_data_wdata = wdata;
      t = 0;
      do begin @(negedge clk); t++; end while (!cpu_data_addr_ok && t < 100);
      if (!cpu_data_addr_ok) begin
         n_vec++; n_err++;
         $display("FAIL addr_ok_timeout: got no addr_ok expected one within 100 cycles");
      end else begin
         model_access(wr, size, addr, wdata, e);
         e.acc_cyc = cyc;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      cpu_data_req = 0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
      if (exp_q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL data_ok_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      check("leftover_beats", beat_q.size(), 0);
      beat_q.delete();
   endtask

   task automatic do_req(input bit wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      issue(wr, size, addr, wdata);
      wait_done();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_cpu_addr_ok"}, cpu_data_addr_ok, 1'b0);
      check({tag, "_cpu_data_ok"}, cpu_data_data_ok, 1'b0);
      check({tag, "_cpu_rdata"}, cpu_data_rdata, 32'd0);
      check({tag, "_mem_req"}, cache_data_req, 1'b0);
      check({tag, "_mem_wr"}, cache_data_wr, 1'b0);
      check({tag, "_mem_size"}, cache_data_size, 2'b10);
      check({tag, "_mem_addr"}, cache_data_addr, 32'd0);
      check({tag, "_mem_wdata"}, cache_data_wdata, 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, t, ix;
      logic [31:0] a;
      logic [1:0]  sz;
      rst = 1; cpu_data_req = 0; cpu_data_wr = 0; cpu_data_size = 0;
      cpu_data_addr = 0; cpu_data_wdata = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check_idle_outputs("reset");

      // Directed, zero-delay bridge: addr_ok and data_ok coincide on every beat.
      max_dly = 0;
      b0 = beats_done; do_req(0, 2'b10, 32'h0000_1234, 0);
      check("cold_load_beats", beats_done - b0, 4);
      b0 = beats_done; do_req(0, 2'b10, 32'h0000_1234, 0);
      check("hit_no_traffic", beats_done - b0, 0);
      do_req(1, 2'b10, 32'h0000_1234, 32'h1122_3344);
      do_req(1, 2'b00, 32'h0000_1236, 32'h00AA_0000);
      do_req(0, 2'b10, 32'h0000_1234, 0);

      // Same set, tags t0..t4; t2 is the PLRU victim and is dirty.
      do_req(0, 2'b10, 32'h0000_1234 + 32'h800 * 1, 0);
      do_req(1, 2'b01, 32'h0000_1236 + 32'h800 * 2, 32'hBEEF_0000);
      do_req(0, 2'b10, 32'h0000_1234 + 32'h800 * 3, 0);
      do_req(0, 2'b10, 32'h0000_1234, 0);
      b0 = beats_done; do_req(0, 2'b10, 32'h0000_1234 + 32'h800 * 4, 0);
      check("evict_dirty_beats", beats_done - b0, 8);

      // Random traffic over three sets and six tags with a slow bridge.
      max_dly = 5;
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(2, 0))
            0:       ix = 32'h23;
            1:       ix = 32'h24;
            default: ix = 32'h10;
         endcase
         sz = 2'($urandom_range(2, 0));
         a  = 32'(($urandom_range(5, 0) << (IW + OW)) | (ix << OW) | $urandom_range(15, 0));
         if (sz == 2'b01) a[0] = 1'b0;
         if (sz == 2'b10) a[1:0] = 2'b00;
         do_req(1'($urandom_range(1, 0)), sz, a, $urandom);
      end

      // Reset while refill beat 2 is in progress.
      max_dly = 0;
      b0 = beats_done;
      issue(0, 2'b10, 32'h0004_5678, 0);
      t = 0;
      while (beats_done < b0 + 2 && t < 200) begin @(posedge clk); t++; end
      if (beats_done < b0 + 2) begin
         n_vec++; n_err++;
         $display("FAIL refill_progress_timeout: got %0d beats expected 2", beats_done - b0);
      end
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      model_reset(); exp_q.delete(); beat_q.delete();
      @(negedge clk);
      check_idle_outputs("mid_refill_reset");
      b0 = beats_done; do_req(0, 2'b10, 32'h0004_5678, 0);
      check("post_reset_miss_beats", beats_done - b0, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
